// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with credit-limited in-order queue (option: FETCH_MISALIGN_TRAP_EN)
module fetch_unit #(
    parameter int unsigned DEPTH     = 2,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        squash,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    output logic        fetch_fault
);

    // Counter width holds outstanding + queued (up to 2*DEPTH) without overflow.
    localparam int CW = $clog2(DEPTH + 1) + 1;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic {ST_RUN = 1'b0, ST_FAULT = 1'b1} state_t;
`else
    typedef enum logic {ST_RUN = 1'b0} state_t;
`endif

    state_t          state_q, state_d;
    logic [31:0]     pc_q;
    logic [31:0]     resp_pc_q;     // PC of the next response that will be kept
    logic [CW-1:0]   outst_q;
    logic [CW-1:0]   drop_q;
    logic [CW-1:0]   q_count;
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [31:0]     q_data [DEPTH];
    logic [31:0]     q_pc   [DEPTH];
    logic [31:0]     instr_q, instr_pc_q;
    logic            instr_valid_q;

    logic            run;
    logic            ack_hs;
    logic            resp_keep;
    logic            resp_drop;
    logic            advance;
    logic            pop;
    logic            push;
    logic [31:0]     redirect_target;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Redirect target: raw address when trapping, word-aligned otherwise.
`ifdef FETCH_MISALIGN_TRAP_EN
    assign redirect_target = redirect_pc;
`else
    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
`endif

    assign run       = (state_q == ST_RUN);
    assign ack_hs    = imem_req & imem_ack;
    // A response arriving with a squash is always discarded, never enqueued.
    assign resp_keep = imem_rvalid & (drop_q == '0) & run & ~squash;
    assign resp_drop = imem_rvalid & (drop_q != '0);
    assign advance   = ~stall & ~squash;
    assign pop       = advance & run & (q_count != '0);
    // When the queue is empty and the output advances, the response bypasses the queue.
    assign push      = resp_keep & ~(advance & (q_count == '0));
    assign imem_addr = pc_q;

    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, request issue under the credit limit, fault flag.
    always_comb begin
        state_d     = state_q;
        imem_req    = 1'b0;
        fetch_fault = 1'b0;
        if (run && !squash && !rst && ((outst_q + q_count) < DEPTH_C)) begin
            imem_req = 1'b1;
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        fetch_fault = (state_q == ST_FAULT);
        if (squash) begin
            state_d = (redirect_pc[1:0] != 2'b00) ? ST_FAULT : ST_RUN;
        end
`endif
    end

    // PC, response tracking, in-flight and drop counters, queue pointers, output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outst_q       <= '0;
            drop_q        <= '0;
            q_count       <= '0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            instr_q       <= NOP_INSTR;
            instr_pc_q    <= 32'h0;
            instr_valid_q <= 1'b0;
        end else begin
            outst_q <= outst_q + CW'(ack_hs) - CW'(imem_rvalid);

            if (squash) begin
                pc_q      <= redirect_target;
                resp_pc_q <= redirect_target;
                // Everything still in flight after this cycle's response is stale.
                drop_q    <= outst_q - CW'(imem_rvalid);
                q_count   <= '0;
                rd_ptr    <= '0;
                wr_ptr    <= '0;
            end else begin
                if (ack_hs) begin
                    pc_q <= pc_q + 32'd4;
                end
                if (resp_keep) begin
                    resp_pc_q <= resp_pc_q + 32'd4;
                end
                if (resp_drop) begin
                    drop_q <= drop_q - ONE_C;
                end
                if (push) begin
                    wr_ptr <= ptr_inc(wr_ptr);
                end
                if (pop) begin
                    rd_ptr <= ptr_inc(rd_ptr);
                end
                q_count <= q_count + CW'(push) - CW'(pop);
            end

            if (squash || !run) begin
                instr_q       <= NOP_INSTR;
                instr_valid_q <= 1'b0;
            end else if (advance) begin
                if (q_count != '0) begin
                    instr_q       <= q_data[rd_ptr];
                    instr_pc_q    <= q_pc[rd_ptr];
                    instr_valid_q <= 1'b1;
                end else if (resp_keep) begin
                    instr_q       <= imem_rdata;
                    instr_pc_q    <= resp_pc_q;
                    instr_valid_q <= 1'b1;
                end else begin
                    instr_q       <= NOP_INSTR;
                    instr_valid_q <= 1'b0;
                end
            end
        end
    end

    // Queue storage; contents are qualified by q_count so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            q_data[wr_ptr] <= imem_rdata;
            q_pc[wr_ptr]   <= resp_pc_q;
        end
    end

`ifndef SYNTHESIS
    // The credit limit must make a push into a full queue impossible.
    assert property (@(posedge clk) disable iff (rst) !(push && (q_count == DEPTH_C)));
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        squash = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        fetch_fault;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          lat = 1;
    logic [31:0] rq_addr [$];
    int          rq_due  [$];
    logic        last_req;
    logic [31:0] last_addr;

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .squash      (squash),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .fetch_fault (fetch_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'hA000_0000 + a;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: drive the memory response due this cycle, note any handshake, sample after the edge.
    task automatic step();
        if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = word(rq_addr[0]);
            void'(rq_addr.pop_front());
            void'(rq_due.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hDEAD_BEEF;
        end
        #1;
        last_req  = imem_req;
        last_addr = imem_addr;
        if (imem_req && imem_ack) begin
            rq_addr.push_back(imem_addr);
            rq_due.push_back(cyc + lat);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rq_addr.delete();
        rq_due.delete();
        step();
        check("rst_req", {31'b0, last_req}, 32'h0);
        step();
        rst = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!instr_valid && n < 20) begin
            step();
            n++;
        end
        check(tag, {31'b0, instr_valid}, 32'h1);
    endtask

    initial begin
        // Reset state
        do_reset();
        check("reset_instr", instr, 32'h0000_0013);
        check("reset_pc", instr_pc, 32'h0);
        check("reset_valid", {31'b0, instr_valid}, 32'h0);
        check("reset_fault", {31'b0, fetch_fault}, 32'h0);

        // Back-to-back stream with 1-cycle latency
        imem_ack = 1'b1;
        lat = 1;
        step();
        check("s1_req", {31'b0, last_req}, 32'h1);
        check("s1_addr", last_addr, 32'h0);
        check("s1_valid", {31'b0, instr_valid}, 32'h0);
        for (int k = 0; k < 4; k++) begin
            step();
            check("stream_addr", last_addr, 32'(4 * (k + 1)));
            check("stream_instr", instr, word(32'(4 * k)));
            check("stream_pc", instr_pc, 32'(4 * k));
            check("stream_valid", {31'b0, instr_valid}, 32'h1);
        end

        // Stall three cycles: output held, credit limit throttles requests
        stall = 1'b1;
        step();
        check("stall1_req", {31'b0, last_req}, 32'h1);
        check("stall1_instr", instr, word(32'hC));
        step();
        check("stall2_req", {31'b0, last_req}, 32'h0);
        check("stall2_pc", instr_pc, 32'hC);
        step();
        check("stall3_req", {31'b0, last_req}, 32'h0);
        check("stall3_instr", instr, word(32'hC));
        check("stall3_valid", {31'b0, instr_valid}, 32'h1);
        stall = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("release_pc", instr_pc, 32'h10 + 32'(4 * k));
            check("release_instr", instr, word(32'h10 + 32'(4 * k)));
        end

        // Squash with two reads outstanding
        do_reset();
        lat = 3;
        step();
        step();
        step();
        check("sq_credit_req", {31'b0, last_req}, 32'h0);
        squash = 1'b1;
        redirect_pc = 32'h100;
        step();
        check("sq_req", {31'b0, last_req}, 32'h0);
        check("sq_valid", {31'b0, instr_valid}, 32'h0);
        check("sq_instr", instr, 32'h0000_0013);
        squash = 1'b0;
        step();
        check("sq_next_valid", {31'b0, instr_valid}, 32'h0);
        check("sq_next_addr", last_addr, 32'h100);
        wait_valid("sq_wait");
        check("sq_first_pc", instr_pc, 32'h100);
        check("sq_first_instr", instr, word(32'h100));

        // Squash and stall together: squash wins
        stall = 1'b1;
        squash = 1'b1;
        redirect_pc = 32'h40;
        step();
        check("sqst_instr", instr, 32'h0000_0013);
        check("sqst_valid", {31'b0, instr_valid}, 32'h0);
        stall = 1'b0;
        squash = 1'b0;
        wait_valid("sqst_wait");
        check("sqst_resume_pc", instr_pc, 32'h40);

        // Ack withheld for 5 cycles: request and address hold
        do_reset();
        lat = 1;
        imem_ack = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check("noack_req", {31'b0, last_req}, 32'h1);
            check("noack_addr", last_addr, 32'h0);
        end
        imem_ack = 1'b1;
        step();
        check("ack_addr0", last_addr, 32'h0);
        step();
        check("ack_addr1", last_addr, 32'h4);
        check("ack_instr", instr, word(32'h0));
        check("ack_pc", instr_pc, 32'h0);

        // Misaligned redirect
        squash = 1'b1;
        redirect_pc = 32'h102;
        step();
        check("mis_valid", {31'b0, instr_valid}, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("mis_fault", {31'b0, fetch_fault}, 32'h1);
        squash = 1'b0;
        step();
        check("mis_fault_req", {31'b0, last_req}, 32'h0);
        check("mis_fault_hold", {31'b0, fetch_fault}, 32'h1);
        check("mis_fault_valid", {31'b0, instr_valid}, 32'h0);
        squash = 1'b1;
        redirect_pc = 32'h200;
        step();
        check("mis_clear", {31'b0, fetch_fault}, 32'h0);
        squash = 1'b0;
        wait_valid("mis_wait");
        check("mis_resume_pc", instr_pc, 32'h200);
        check("mis_resume_instr", instr, word(32'h200));
`else
        check("mis_nofault", {31'b0, fetch_fault}, 32'h0);
        squash = 1'b0;
        wait_valid("mis_wait");
        check("mis_align_pc", instr_pc, 32'h100);
        check("mis_align_instr", instr, word(32'h100));
        check("mis_nofault2", {31'b0, fetch_fault}, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
